// File: rtl/axil_cfg_pkg.sv
// Shared types and the boot-time register table for the AXI4-Lite configuration sequencer.
// Readback verification is enabled by defining AXIL_CFG_VERIFY_EN.
package axil_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_REQ,
        W_RESP,
        R_REQ,
        R_DATA,
        FINISH
    } cfg_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } cfg_entry_t;

    // Deepest table a build may ask for; N_ENTRIES picks a prefix of it.
    localparam int CFG_DEPTH = 16;

    localparam cfg_entry_t [0:CFG_DEPTH-1] CFG_TABLE = '{
        '{addr: 32'h0000_0000, data: 32'h1111_1111},
        '{addr: 32'h0000_0004, data: 32'h2222_2222},
        '{addr: 32'h0000_0008, data: 32'h3333_3333},
        '{addr: 32'h0000_000C, data: 32'h4444_4444},
        '{addr: 32'h0000_0000, data: 32'h5555_0004},
        '{addr: 32'h0000_0004, data: 32'h5555_0005},
        '{addr: 32'h0000_0008, data: 32'h5555_0006},
        '{addr: 32'h0000_000C, data: 32'h5555_0007},
        '{addr: 32'h0000_0000, data: 32'h6666_0008},
        '{addr: 32'h0000_0004, data: 32'h6666_0009},
        '{addr: 32'h0000_0008, data: 32'h6666_000A},
        '{addr: 32'h0000_000C, data: 32'h6666_000B},
        '{addr: 32'h0000_0000, data: 32'h7777_000C},
        '{addr: 32'h0000_0004, data: 32'h7777_000D},
        '{addr: 32'h0000_0008, data: 32'h7777_000E},
        '{addr: 32'h0000_000C, data: 32'h7777_000F}
    };

endpackage

// File: rtl/axil_cfg_if.sv
// AXI4-Lite bus bundle between the configuration sequencer and the register slave.
// Read channels are only exercised when AXIL_CFG_VERIFY_EN is defined.
interface axil_cfg_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axil_cfg_rom.sv
// Combinational lookup of one configuration table entry by index.
// Indices at or beyond N_ENTRIES read back as all-zero.
module axil_cfg_rom
    import axil_cfg_pkg::*;
#(
    parameter int N_ENTRIES = 4,
    parameter int IDX_W     = 3
) (
    input  logic [IDX_W-1:0] idx,
    output cfg_entry_t       entry
);

    // Select the table row matching idx.
    always_comb begin
        entry = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (idx == IDX_W'(i)) entry = CFG_TABLE[i[3:0]];
        end
    end

endmodule

// File: rtl/axil_cfg_sequencer.sv
// AXI4-Lite master that writes the boot table into the register slave on start.
// Define AXIL_CFG_VERIFY_EN to read back and compare every entry after writing it.
module axil_cfg_sequencer
    import axil_cfg_pkg::*;
#(
    parameter int N_ENTRIES = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       start,
    output logic       done,
    output logic       err,
    axil_cfg_if.master m_axil
);

    localparam int IDX_W = $clog2(N_ENTRIES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

    cfg_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  ld_idx;
    cfg_entry_t        entry;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              advance;
    logic              abort;
`ifdef AXIL_CFG_VERIFY_EN
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
`endif

    // Entry to load next: row 0 on a fresh run, otherwise the following row.
    always_comb begin
        ld_idx = (state_q == IDLE) ? '0 : idx_q + 1'b1;
    end

    axil_cfg_rom #(
        .N_ENTRIES (N_ENTRIES),
        .IDX_W     (IDX_W)
    ) u_rom (
        .idx   (ld_idx),
        .entry (entry)
    );

    // State register and registered bus outputs.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
`ifdef AXIL_CFG_VERIFY_EN
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
`ifdef AXIL_CFG_VERIFY_EN
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            araddr_q  <= araddr_d;
`endif
        end
    end

    // Next-state and next-output decode for the table walk.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        done_d    = done_q;
        err_d     = err_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
`ifdef AXIL_CFG_VERIFY_EN
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        araddr_d  = araddr_q;
`endif
        advance   = 1'b0;
        abort     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    idx_d     = '0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = ADDR_W'(entry.addr);
                    wdata_d   = DATA_W'(entry.data);
                    state_d   = W_REQ;
                end
            end
            W_REQ: begin
                // AW and W complete independently; wait for both.
                awvalid_d = awvalid_q & ~m_axil.awready;
                wvalid_d  = wvalid_q & ~m_axil.wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = W_RESP;
                end
            end
            W_RESP: begin
                if (m_axil.bvalid) begin
                    bready_d = 1'b0;
                    if (m_axil.bresp != RESP_OKAY) begin
                        abort = 1'b1;
                    end else begin
`ifdef AXIL_CFG_VERIFY_EN
                        arvalid_d = 1'b1;
                        araddr_d  = awaddr_q;
                        state_d   = R_REQ;
`else
                        advance = 1'b1;
`endif
                    end
                end
            end
`ifdef AXIL_CFG_VERIFY_EN
            R_REQ: begin
                if (m_axil.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R_DATA;
                end
            end
            R_DATA: begin
                // wdata_q still holds this entry's data.
                if (m_axil.rvalid) begin
                    rready_d = 1'b0;
                    if (m_axil.rresp != RESP_OKAY ||
                        m_axil.rdata != wdata_q) begin
                        abort = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
`endif
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = FINISH;
        end else if (advance) begin
            if (idx_q == LAST_IDX) begin
                done_d  = 1'b1;
                state_d = FINISH;
            end else begin
                idx_d     = idx_q + 1'b1;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                awaddr_d  = ADDR_W'(entry.addr);
                wdata_d   = DATA_W'(entry.data);
                state_d   = W_REQ;
            end
        end
    end

    assign done           = done_q;
    assign err            = err_q;
    assign m_axil.awaddr  = awaddr_q;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = 4'hF;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.bready  = bready_q;
`ifdef AXIL_CFG_VERIFY_EN
    assign m_axil.araddr  = araddr_q;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.rready  = rready_q;
`else
    assign m_axil.araddr  = '0;
    assign m_axil.arvalid = 1'b0;
    assign m_axil.rready  = 1'b0;
`endif

endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// Directed bench for axil_cfg_sequencer against a 4-register AXI4-Lite slave model.
// Define AXIL_CFG_VERIFY_EN to also exercise the readback path.
`timescale 1ns/1ps
module tb_axil_cfg_sequencer;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic start   = 1'b0;
    logic done;
    logic err;

    int n_checks = 0;
    int n_pass   = 0;

    axil_cfg_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axil_cfg_sequencer #(
        .N_ENTRIES (4),
        .ADDR_W    (32),
        .DATA_W    (32)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .start   (start),
        .done    (done),
        .err     (err),
        .m_axil  (bus)
    );

    always #5 aclk = ~aclk;

    // Slave model knobs and observation
    int          aw_delay = 0;
    int          aw_cnt   = 0;
    bit          err_en   = 1'b0;
    logic [31:0] err_addr = 32'h0;
    bit          bad_en   = 1'b0;
    logic [31:0] bad_addr = 32'h0;
    logic [31:0] regs [4];
    logic [31:0] wr_log [$];
    int          b_count  = 0;
    int          ar_count = 0;
    bit          have_aw  = 1'b0;
    bit          have_w   = 1'b0;
    logic [31:0] aw_a;
    logic [31:0] w_d;

    assign bus.awready = (aw_cnt >= aw_delay);
    assign bus.wready  = 1'b1;
    assign bus.arready = 1'b1;

    // Slave: one outstanding write, B one cycle after AW+W, R one cycle after AR.
    always @(posedge aclk) begin
        if (!aresetn) begin
            have_aw    <= 1'b0;
            have_w     <= 1'b0;
            aw_cnt     <= 0;
            bus.bvalid <= 1'b0;
            bus.bresp  <= 2'b00;
            bus.rvalid <= 1'b0;
            bus.rresp  <= 2'b00;
            bus.rdata  <= 32'h0;
        end else begin
            if (bus.awvalid && bus.awready) begin
                have_aw <= 1'b1;
                aw_a    <= bus.awaddr;
                aw_cnt  <= 0;
            end else if (bus.awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (bus.wvalid && bus.wready) begin
                have_w <= 1'b1;
                w_d    <= bus.wdata;
            end
            if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0;
                b_count    <= b_count + 1;
            end
            if (have_aw && have_w && !bus.bvalid) begin
                regs[aw_a[3:2]] <= w_d;
                wr_log.push_back(aw_a);
                bus.bvalid <= 1'b1;
                bus.bresp  <= (err_en && aw_a == err_addr) ? 2'b10 : 2'b00;
                have_aw    <= 1'b0;
                have_w     <= 1'b0;
            end
            if (bus.arvalid && bus.arready && !bus.rvalid) begin
                bus.rvalid <= 1'b1;
                bus.rresp  <= 2'b00;
                bus.rdata  <= regs[bus.araddr[3:2]] ^
                              ((bad_en && bus.araddr == bad_addr) ? 32'h3 : 32'h0);
                ar_count   <= ar_count + 1;
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
        end
    end

    task automatic pulse_start();
        @(negedge aclk);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge aclk);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_checks++; if (bus.awvalid !== 1'b0) $display("FAIL rst_awvalid got %b want 0", bus.awvalid); else n_pass++;
        n_checks++; if (bus.wvalid !== 1'b0) $display("FAIL rst_wvalid got %b want 0", bus.wvalid); else n_pass++;
        n_checks++; if (bus.bready !== 1'b0) $display("FAIL rst_bready got %b want 0", bus.bready); else n_pass++;
        n_checks++; if (bus.arvalid !== 1'b0) $display("FAIL rst_arvalid got %b want 0", bus.arvalid); else n_pass++;
        n_checks++; if (bus.rready !== 1'b0) $display("FAIL rst_rready got %b want 0", bus.rready); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else n_pass++;
        n_checks++; if (bus.awaddr !== 32'h0) $display("FAIL rst_awaddr got %h want 0", bus.awaddr); else n_pass++;
        n_checks++; if (bus.wdata !== 32'h0) $display("FAIL rst_wdata got %h want 0", bus.wdata); else n_pass++;
        n_checks++; if (bus.araddr !== 32'h0) $display("FAIL rst_araddr got %h want 0", bus.araddr); else n_pass++;
        n_checks++; if (bus.wstrb !== 4'hF) $display("FAIL rst_wstrb got %h want f", bus.wstrb); else n_pass++;
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_basic();
        bit ok;
        int l0 = wr_log.size();
        int b0 = b_count;
        int a0 = ar_count;
        pulse_start();
        wait_done(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL basic_done_timeout got %b want 1", ok); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL basic_err got %b want 0", err); else n_pass++;
        n_checks++; if (wr_log.size() - l0 != 4) $display("FAIL basic_nwrites got %0d want 4", wr_log.size() - l0); else n_pass++;
        n_checks++; if (b_count - b0 != 4) $display("FAIL basic_nb got %0d want 4", b_count - b0); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_a;
            logic [31:0] exp_d;
            exp_a = 32'(k * 4);
            exp_d = 32'(32'h1111_1111 * (k + 1));
            if (l0 + k < wr_log.size()) begin
                n_checks++; if (wr_log[l0 + k] !== exp_a) $display("FAIL basic_order%0d got %h want %h", k, wr_log[l0 + k], exp_a); else n_pass++;
            end
            n_checks++; if (regs[k] !== exp_d) $display("FAIL basic_reg%0d got %h want %h", k, regs[k], exp_d); else n_pass++;
        end
`ifdef AXIL_CFG_VERIFY_EN
        n_checks++; if (ar_count - a0 != 4) $display("FAIL basic_nreads got %0d want 4", ar_count - a0); else n_pass++;
`else
        n_checks++; if (ar_count - a0 != 0) $display("FAIL basic_nreads got %0d want 0", ar_count - a0); else n_pass++;
`endif
    endtask

    task automatic test_aw_delay();
        bit ok;
        int l0 = wr_log.size();
        aw_delay = 2;
        pulse_start();
        n_checks++; if ({bus.awvalid, bus.wvalid, bus.awready} !== 3'b110) $display("FAIL awdly_c1 got %b want 110", {bus.awvalid, bus.wvalid, bus.awready}); else n_pass++;
        @(negedge aclk);
        n_checks++; if ({bus.awvalid, bus.wvalid} !== 2'b10) $display("FAIL awdly_c2 got %b want 10", {bus.awvalid, bus.wvalid}); else n_pass++;
        n_checks++; if (bus.awaddr !== 32'h0) $display("FAIL awdly_addr2 got %h want 0", bus.awaddr); else n_pass++;
        @(negedge aclk);
        n_checks++; if ({bus.awvalid, bus.wvalid, bus.awready} !== 3'b101) $display("FAIL awdly_c3 got %b want 101", {bus.awvalid, bus.wvalid, bus.awready}); else n_pass++;
        n_checks++; if (bus.awaddr !== 32'h0) $display("FAIL awdly_addr3 got %h want 0", bus.awaddr); else n_pass++;
        wait_done(ok);
        aw_delay = 0;
        n_checks++; if (ok !== 1'b1) $display("FAIL awdly_done_timeout got %b want 1", ok); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL awdly_err got %b want 0", err); else n_pass++;
        n_checks++; if (wr_log.size() - l0 != 4) $display("FAIL awdly_nwrites got %0d want 4", wr_log.size() - l0); else n_pass++;
    endtask

    task automatic test_bresp_err();
        bit ok;
        int l0 = wr_log.size();
        err_en   = 1'b1;
        err_addr = 32'h4;
        pulse_start();
        wait_done(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL berr_done_timeout got %b want 1", ok); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL berr_err got %b want 1", err); else n_pass++;
        repeat (10) @(negedge aclk);
        err_en = 1'b0;
        n_checks++; if (wr_log.size() - l0 != 2) $display("FAIL berr_nwrites got %0d want 2", wr_log.size() - l0); else n_pass++;
        n_checks++; if (bus.bready !== 1'b0) $display("FAIL berr_idle_bready got %b want 0", bus.bready); else n_pass++;
        n_checks++; if (bus.awvalid !== 1'b0) $display("FAIL berr_idle_awvalid got %b want 0", bus.awvalid); else n_pass++;
        n_checks++; if ({done, err} !== 2'b11) $display("FAIL berr_sticky got %b want 11", {done, err}); else n_pass++;
    endtask

`ifdef AXIL_CFG_VERIFY_EN
    task automatic test_verify_mismatch();
        bit ok;
        int l0 = wr_log.size();
        int a0 = ar_count;
        bad_en   = 1'b1;
        bad_addr = 32'h8;
        pulse_start();
        wait_done(ok);
        repeat (10) @(negedge aclk);
        bad_en = 1'b0;
        n_checks++; if (ok !== 1'b1) $display("FAIL vfy_done_timeout got %b want 1", ok); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL vfy_err got %b want 1", err); else n_pass++;
        n_checks++; if (wr_log.size() - l0 != 3) $display("FAIL vfy_nwrites got %0d want 3", wr_log.size() - l0); else n_pass++;
        n_checks++; if (ar_count - a0 != 3) $display("FAIL vfy_nreads got %0d want 3", ar_count - a0); else n_pass++;
    endtask
`endif

    task automatic test_start_ignored();
        bit ok;
        bit hit = 1'b0;
        int l0 = wr_log.size();
        int b0 = b_count;
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            if (b_count - b0 == 2 && bus.bready) begin
                hit = 1'b1;
                break;
            end
            @(negedge aclk);
        end
        n_checks++; if (hit !== 1'b1) $display("FAIL ign_reach_entry2 got %b want 1", hit); else n_pass++;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        n_checks++; if ({done, err} !== 2'b00) $display("FAIL ign_midrun got %b want 00", {done, err}); else n_pass++;
        wait_done(ok);
        repeat (10) @(negedge aclk);
        n_checks++; if (ok !== 1'b1) $display("FAIL ign_done_timeout got %b want 1", ok); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL ign_err got %b want 0", err); else n_pass++;
        n_checks++; if (b_count - b0 != 4) $display("FAIL ign_nb got %0d want 4", b_count - b0); else n_pass++;
        n_checks++; if (wr_log.size() - l0 != 4) $display("FAIL ign_nwrites got %0d want 4", wr_log.size() - l0); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        bit ok;
        bit hit = 1'b0;
        int l0 = wr_log.size();
        int l1;
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            if (bus.awvalid && bus.awaddr == 32'h8) begin
                hit = 1'b1;
                break;
            end
            @(negedge aclk);
        end
        n_checks++; if (hit !== 1'b1) $display("FAIL mrst_reach_entry2 got %b want 1", hit); else n_pass++;
        aresetn = 1'b0;
        @(negedge aclk);
        n_checks++; if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b000) $display("FAIL mrst_valids got %b want 000", {bus.awvalid, bus.wvalid, bus.bready}); else n_pass++;
        n_checks++; if ({done, err} !== 2'b00) $display("FAIL mrst_flags got %b want 00", {done, err}); else n_pass++;
        n_checks++; if (bus.awaddr !== 32'h0) $display("FAIL mrst_awaddr got %h want 0", bus.awaddr); else n_pass++;
        aresetn = 1'b1;
        @(negedge aclk);
        l1 = wr_log.size();
        n_checks++; if (l1 - l0 != 2) $display("FAIL mrst_partial got %0d want 2", l1 - l0); else n_pass++;
        pulse_start();
        wait_done(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL mrst_done_timeout got %b want 1", ok); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL mrst_err got %b want 0", err); else n_pass++;
        n_checks++; if (wr_log.size() - l1 != 4) $display("FAIL mrst_nwrites got %0d want 4", wr_log.size() - l1); else n_pass++;
        if (wr_log.size() > l1) begin
            n_checks++; if (wr_log[l1] !== 32'h0) $display("FAIL mrst_first_addr got %h want 0", wr_log[l1]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_aw_delay();
        test_bresp_err();
`ifdef AXIL_CFG_VERIFY_EN
        test_verify_mismatch();
`endif
        test_start_ignored();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
